// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer driven by ticks derived from clock_divider's output level.
// Supports OFF, SOLID, BLINK (programmable on/off tick counts) and CHASE (one-hot walk).
module led_pattern_sequencer #(
  parameter int NUM_LEDS  = 8,
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 2
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                div_clk_in,
  input  logic [1:0]          mode_in,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                tick_out,
  output logic                phase_out
);

  if (NUM_LEDS < 2) begin : g_chk_leds
    $fatal(1, "led_pattern_sequencer: NUM_LEDS must be >= 2");
  end
  if (ON_TICKS < 1) begin : g_chk_on
    $fatal(1, "led_pattern_sequencer: ON_TICKS must be >= 1");
  end
  if (OFF_TICKS < 1) begin : g_chk_off
    $fatal(1, "led_pattern_sequencer: OFF_TICKS must be >= 1");
  end

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam int POS_W     = $clog2(NUM_LEDS);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_SOLID = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_CHASE = 2'b11
  } mode_t;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_t;

  mode_t            mode_q, mode_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             div_q;
  logic             tick;
  logic             mode_change;

  // div_q resets high so a divider output already high at release is not seen as an edge
  assign tick        = div_clk_in & ~div_q;
  assign mode_change = (mode_t'(mode_in) != mode_q);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      phase_q  <= PHASE_ON;
      cnt_q    <= '0;
      pos_q    <= '0;
      div_q    <= 1'b1;
      tick_out <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      div_q    <= div_clk_in;
      tick_out <= tick;
    end
  end

  // A mode change restarts sequencing and swallows any tick arriving in the same cycle
  always_comb begin
    mode_d    = mode_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    led_out   = '0;
    phase_out = 1'b0;

    if (mode_change) begin
      mode_d  = mode_t'(mode_in);
      phase_d = PHASE_ON;
      cnt_d   = '0;
      pos_d   = '0;
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: begin
          if (phase_q == PHASE_ON) begin
            if (cnt_q == ON_LAST) begin
              phase_d = PHASE_OFF;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            if (cnt_q == OFF_LAST) begin
              phase_d = PHASE_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        MODE_CHASE: begin
          pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        end
        default: begin
        end
      endcase
    end

    case (mode_q)
      MODE_SOLID: led_out = {NUM_LEDS{1'b1}};
      MODE_BLINK: begin
        led_out   = (phase_q == PHASE_ON) ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};
        phase_out = (phase_q == PHASE_ON);
      end
      MODE_CHASE: led_out = {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos_q;
      default:    led_out = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed scenarios plus random modes/resets,
// checked every cycle against a tick-count model of the LED patterns.
module tb_led_pattern_sequencer;

  localparam int NL       = 8;
  localparam int ON_T     = 3;
  localparam int OFF_T    = 2;
  localparam int PERIOD_T = ON_T + OFF_T;

  logic          clk_in     = 1'b0;
  logic          rst        = 1'b0;
  logic          div_clk_in = 1'b0;
  logic [1:0]    mode_in    = 2'd0;
  logic [NL-1:0] led_out;
  logic          tick_out;
  logic          phase_out;

  int vectors     = 0;
  int miscompares = 0;
  int div_phase   = 0;

  // Model: pattern position is just the number of ticks seen since the mode was entered
  logic [1:0] m_mode   = 2'd0;
  logic       m_div_q  = 1'b1;
  logic       m_tick_q = 1'b0;
  int         m_k      = 0;
  logic       prev_tick = 1'b0;

  led_pattern_sequencer #(
    .NUM_LEDS (NL),
    .ON_TICKS (ON_T),
    .OFF_TICKS(OFF_T)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .div_clk_in(div_clk_in),
    .mode_in   (mode_in),
    .led_out   (led_out),
    .tick_out  (tick_out),
    .phase_out (phase_out)
  );

  always #10 clk_in = ~clk_in;

  function automatic logic m_lit();
    return (m_k % PERIOD_T) < ON_T;
  endfunction

  function automatic logic [NL-1:0] exp_led();
    case (m_mode)
      2'd0:    return '0;
      2'd1:    return {NL{1'b1}};
      2'd2:    return m_lit() ? {NL{1'b1}} : {NL{1'b0}};
      default: return NL'(1) << (m_k % NL);
    endcase
  endfunction

  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_mode   <= 2'd0;
      m_div_q  <= 1'b1;
      m_tick_q <= 1'b0;
      m_k      <= 0;
    end else begin
      m_div_q  <= div_clk_in;
      m_tick_q <= div_clk_in & ~m_div_q;
      if (mode_in != m_mode) begin
        m_mode <= mode_in;
        m_k    <= 0;
      end else if ((div_clk_in & ~m_div_q) && m_mode >= 2'd2) begin
        m_k <= m_k + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Divided clock mimics clock_divider RATE=3: three cycles high, three low
  task automatic applyStimulus(input logic [1:0] mode);
    @(negedge clk_in);
    mode_in    = mode;
    div_phase  = (div_phase + 1) % 6;
    div_clk_in = (div_phase >= 3);
  endtask

  always @(negedge clk_in) begin
    checkOutput("led_out", 32'(led_out), 32'(exp_led()));
    checkOutput("tick_out", 32'(tick_out), 32'(m_tick_q));
    checkOutput("phase_out", 32'(phase_out), 32'(m_mode == 2'd2 && m_lit()));
    if (prev_tick) checkOutput("tick_pulse_width", 32'(tick_out), 32'd0);
    if (m_mode == 2'd3) checkOutput("chase_onehot", 32'($onehot(led_out)), 32'd1);
    if (m_mode == 2'd2) checkOutput("blink_uniform", 32'(led_out == '0 || led_out == '1), 32'd1);
    prev_tick <= tick_out;
  end

  logic [NL-1:0] samples[$];
  int            run_len[$];
  logic [NL-1:0] run_val[$];
  logic [NL-1:0] chase_seq[$];
  logic [NL-1:0] chase_exp[9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  int            on_cnt;
  int            ticks;
  logic [1:0]    cur_mode;

  initial begin
    #1 rst = 1'b1;
    while (div_phase != 3) applyStimulus(2'd0);
    checkOutput("reset_led", 32'(led_out), 32'd0);
    checkOutput("reset_tick", 32'(tick_out), 32'd0);
    checkOutput("reset_phase", 32'(phase_out), 32'd0);
    rst = 1'b0;
    applyStimulus(2'd0);
    checkOutput("no_tick_after_release", 32'(tick_out), 32'd0);

    // BLINK steady-state run lengths: 18 cycles lit, 12 dark
    repeat (2) applyStimulus(2'd2);
    repeat (80) begin
      applyStimulus(2'd2);
      samples.push_back(led_out);
    end
    foreach (samples[i]) begin
      if (i > 0 && samples[i] == samples[i-1]) begin
        run_len[$] += 1;
      end else begin
        run_len.push_back(1);
        run_val.push_back(samples[i]);
      end
    end
    checkOutput("blink_off_run", run_len[1], 32'd12);
    checkOutput("blink_off_val", 32'(run_val[1]), 32'h00);
    checkOutput("blink_on_run", run_len[2], 32'd18);
    checkOutput("blink_on_val", 32'(run_val[2]), 32'hFF);
    checkOutput("blink_off_run2", run_len[3], 32'd12);

    // Asynchronous reset in the middle of an ON phase
    for (int i = 0; i < 40 && !(m_mode == 2'd2 && m_lit() && m_k >= 1); i++) applyStimulus(2'd2);
    checkOutput("pre_reset_led", 32'(led_out), 32'hFF);
    @(posedge clk_in);
    #5 rst = 1'b1;
    #1;
    checkOutput("async_reset_led", 32'(led_out), 32'd0);
    checkOutput("async_reset_phase", 32'(phase_out), 32'd0);
    applyStimulus(2'd2);
    rst = 1'b0;
    repeat (10) applyStimulus(2'd2);

    // CHASE walk including the wrap back to LED 0
    applyStimulus(2'd3);
    for (int i = 0; i < 80 && chase_seq.size() < 9; i++) begin
      applyStimulus(2'd3);
      if (chase_seq.size() == 0 || led_out != chase_seq[$]) chase_seq.push_back(led_out);
    end
    checkOutput("chase_len", chase_seq.size(), 32'd9);
    for (int i = 0; i < 9 && i < chase_seq.size(); i++) checkOutput("chase_step", 32'(chase_seq[i]), 32'(chase_exp[i]));

    // Switch to BLINK on the very edge that carries a tick
    for (int i = 0; i < 6 && div_phase != 2; i++) applyStimulus(2'd3);
    applyStimulus(2'd2);
    on_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(2'd2);
      if (led_out != 8'hFF) break;
      on_cnt++;
    end
    checkOutput("blink_after_tick_switch", on_cnt, 32'd18);

    // OFF and SOLID hold steady while ticks keep pulsing
    applyStimulus(2'd0);
    ticks = 0;
    repeat (30) begin
      applyStimulus(2'd0);
      checkOutput("off_led", 32'(led_out), 32'h00);
      ticks += int'(tick_out);
    end
    checkOutput("off_ticks", ticks, 32'd5);
    applyStimulus(2'd1);
    ticks = 0;
    repeat (30) begin
      applyStimulus(2'd1);
      checkOutput("solid_led", 32'(led_out), 32'hFF);
      ticks += int'(tick_out);
    end
    checkOutput("solid_ticks", ticks, 32'd5);

    // Random modes and occasional mid-operation resets
    cur_mode = 2'd2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom_range(0, 3));
      applyStimulus(cur_mode);
      if ($urandom_range(0, 199) == 0) begin
        #3 rst = 1'b1;
        repeat ($urandom_range(1, 3)) applyStimulus(cur_mode);
        rst = 1'b0;
      end
    end
    repeat (2) applyStimulus(cur_mode);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
